// File: rtl/div_check_sched.sv
// Round-robin scheduler sharing one serial modulo-DIVISOR residue engine among NREQ requesters.
// Words are fed MSB-first; the residue and divisibility flag go back to the granted requester.
`default_nettype none

module div_check_sched #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 8,
  parameter int DIVISOR = 5,
  localparam int RW     = (DIVISOR <= 2) ? 1 : $clog2(DIVISOR),
  localparam int IW     = (NREQ <= 2) ? 1 : $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  ser_bit,
  output logic                  done,
  output logic [IW-1:0]         done_id,
  output logic                  divisible,
  output logic [RW-1:0]         residue
);

  localparam int CW = (WIDTH <= 2) ? 1 : $clog2(WIDTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [RW:0]   DIV_W    = (RW+1)'(DIVISOR);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH-1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NREQ-1);

  logic [1:0]       state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    sel_q, sel_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [RW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    done_id_q, done_id_d;
  logic [RW-1:0]    residue_q, residue_d;
  logic             div_q, div_d;

  logic [WIDTH-1:0] word [NREQ];
  logic             found;
  logic [IW-1:0]    pick;
  logic [IW-1:0]    cand;
  int               idx;
  logic             bit_w;
  logic [RW:0]      dbl;
  logic [RW-1:0]    acc_next;

  for (genvar g = 0; g < NREQ; g++) begin : g_words
    assign word[g] = req_data[g*WIDTH +: WIDTH];
  end

  // First requesting index at or after ptr, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx  = (int'(ptr_q) + k) % NREQ;
      cand = idx[IW-1:0];
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign bit_w    = shift_q[WIDTH-1];
  assign dbl      = {acc_q, bit_w};
  assign acc_next = (dbl >= DIV_W) ? RW'(dbl - DIV_W) : RW'(dbl);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    gnt_d     = gnt_q;
    shift_d   = shift_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    done_id_d = done_id_q;
    residue_d = residue_q;
    div_d     = div_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          sel_d   = pick;
          gnt_d   = NREQ'(1) << pick;
          shift_d = word[pick];
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shift_d = shift_q << 1;
        acc_d   = acc_next;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d   = S_DONE;
          done_id_d = sel_q;
          residue_d = acc_next;
          div_d     = (acc_next == '0);
        end
      end
      S_DONE: begin
        gnt_d   = '0;
        ptr_d   = (sel_q == IDX_LAST) ? '0 : sel_q + 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      sel_q     <= '0;
      gnt_q     <= '0;
      shift_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      done_id_q <= '0;
      residue_q <= '0;
      div_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      gnt_q     <= gnt_d;
      shift_q   <= shift_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      done_id_q <= done_id_d;
      residue_q <= residue_d;
      div_q     <= div_d;
    end
  end

  assign gnt       = gnt_q;
  assign busy      = (state_q != S_IDLE);
  assign ser_bit   = (state_q == S_SHIFT) ? bit_w : 1'b0;
  assign done      = (state_q == S_DONE);
  assign done_id   = done_id_q;
  assign residue   = residue_q;
  assign divisible = div_q;

endmodule

`default_nettype wire

// File: tb/tb_div_check_sched.sv
// Randomised and directed checks of div_check_sched against a plain-arithmetic round-robin model.
`default_nettype none

module tb_div_check_sched;

  localparam int NREQ = 4, WIDTH = 8, DIVISOR = 5, IW = 2, RW = 3;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] req_data = '0;
  logic [NREQ-1:0]       gnt;
  logic                  busy, ser_bit, done, divisible;
  logic [IW-1:0]         done_id;
  logic [RW-1:0]         residue;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  div_check_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .DIVISOR(DIVISOR)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .gnt(gnt), .busy(busy),
    .ser_bit(ser_bit), .done(done), .done_id(done_id), .divisible(divisible), .residue(residue)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    req   = '0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic set_word(input int i, input logic [WIDTH-1:0] w);
    req_data[i*WIDTH +: WIDTH] = w;
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    req      = 4'b1111;
    req_data = $urandom();
    for (int c = 0; c < 2; c++) begin
      tick();
      tests++;
      if ({gnt, busy, done, residue, divisible, ser_bit, done_id} !== '0) begin
        fails++;
        $display("FAIL reset_outputs: got gnt=%b busy=%b done=%b res=%0d div=%b ser=%b id=%0d, expected all 0",
                 gnt, busy, done, residue, divisible, ser_bit, done_id);
      end
    end
    reset = 1'b1;
    req   = '0;
    tick();
  endtask

  task automatic test_single();
    int n;
    apply_reset();
    set_word(0, 8'd25);
    req = 4'b0001;
    tick();
    tests++;
    if (gnt !== 4'b0001 || busy !== 1'b1) begin
      fails++; $display("FAIL single_grant: got gnt=%b busy=%b, expected 0001 1", gnt, busy);
    end
    n = 0;
    while (done !== 1'b1 && n < 20) begin tick(); n++; end
    tests++;
    if (n !== WIDTH) begin
      fails++; $display("FAIL single_latency: got %0d cycles, expected %0d", n, WIDTH);
    end
    tests++;
    if (done_id !== 2'd0 || residue !== 3'd0 || divisible !== 1'b1) begin
      fails++; $display("FAIL single_result: got id=%0d res=%0d div=%b, expected 0 0 1", done_id, residue, divisible);
    end
    req = '0;
    tick();
    tests++;
    if (done !== 1'b0 || busy !== 1'b0 || gnt !== 4'b0000 || residue !== 3'd0 || divisible !== 1'b1) begin
      fails++; $display("FAIL single_release: got done=%b busy=%b gnt=%b res=%0d div=%b, expected 0 0 0000 0 1",
                        done, busy, gnt, residue, divisible);
    end
  endtask

  task automatic test_trace();
    logic [WIDTH-1:0] w;
    apply_reset();
    w = 8'd23;
    set_word(1, w);
    req = 4'b0010;
    tick();
    tests++;
    if (gnt !== 4'b0010) begin
      fails++; $display("FAIL trace_grant: got %b expected 0010", gnt);
    end
    for (int b = WIDTH-1; b >= 0; b--) begin
      tests++;
      if (ser_bit !== w[b]) begin
        fails++; $display("FAIL trace_ser_bit[%0d]: got %b expected %b", b, ser_bit, w[b]);
      end
      tick();
    end
    tests++;
    if (done !== 1'b1 || done_id !== 2'd1 || residue !== 3'd3 || divisible !== 1'b0) begin
      fails++; $display("FAIL trace_result: got done=%b id=%0d res=%0d div=%b, expected 1 1 3 0",
                        done, done_id, residue, divisible);
    end
    req = '0;
    tick();
  endtask

  task automatic test_round_robin();
    int n, last, exp_i, exp_r;
    apply_reset();
    for (int i = 0; i < NREQ; i++) set_word(i, WIDTH'(10 + i));
    req  = 4'b1111;
    last = 0;
    for (int t = 0; t < 5; t++) begin
      exp_i = t % NREQ;
      exp_r = (10 + exp_i) % DIVISOR;
      n = 0;
      while (gnt === 4'b0000 && n < 20) begin tick(); n++; end
      tests++;
      if (gnt !== 4'(1 << exp_i)) begin
        fails++; $display("FAIL rr_grant[%0d]: got %b expected %b", t, gnt, 4'(1 << exp_i));
      end
      if (t > 0) begin
        tests++;
        if (cyc - last !== WIDTH + 2) begin
          fails++; $display("FAIL rr_spacing[%0d]: got %0d expected %0d", t, cyc - last, WIDTH + 2);
        end
      end
      last = cyc;
      n = 0;
      while (done !== 1'b1 && n < 20) begin tick(); n++; end
      tests++;
      if (done !== 1'b1 || done_id !== IW'(exp_i) || residue !== RW'(exp_r) || divisible !== (exp_r == 0)) begin
        fails++; $display("FAIL rr_result[%0d]: got done=%b id=%0d res=%0d div=%b, expected 1 %0d %0d %b",
                          t, done, done_id, residue, divisible, exp_i, exp_r, exp_r == 0);
      end
      if (t == 4) req = '0;
      tick();
    end
  endtask

  task automatic test_reset_midway();
    int n;
    apply_reset();
    set_word(2, 8'hAB);
    req = 4'b0100;
    tick();
    tests++;
    if (gnt !== 4'b0100) begin
      fails++; $display("FAIL abort_grant: got %b expected 0100", gnt);
    end
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b0;
    tick();
    tests++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL abort_clear: got gnt=%b busy=%b done=%b, expected 0000 0 0", gnt, busy, done);
    end
    reset = 1'b1;
    set_word(0, 8'd77);
    req = 4'b0101;
    tick();
    tests++;
    if (gnt !== 4'b0001) begin
      fails++; $display("FAIL abort_ptr_restart: got %b expected 0001", gnt);
    end
    n = 0;
    while (done !== 1'b1 && n < 20) begin tick(); n++; end
    tests++;
    if (n !== WIDTH || done_id !== 2'd0 || residue !== 3'd2 || divisible !== 1'b0) begin
      fails++; $display("FAIL abort_followup: got n=%0d id=%0d res=%0d div=%b, expected %0d 0 2 0",
                        n, done_id, residue, divisible, WIDTH);
    end
    req = '0;
    tick();
  endtask

  task automatic test_edge_words();
    logic [WIDTH-1:0] words [3];
    logic [WIDTH-1:0] w;
    int exp_r;
    words[0] = 8'd255; words[1] = 8'd0; words[2] = 8'd254;
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      w     = words[k];
      exp_r = int'(w) % DIVISOR;
      set_word(3, w);
      req = 4'b1000;
      tick();
      tests++;
      if (gnt !== 4'b1000) begin
        fails++; $display("FAIL edge_grant[%0d]: got %b expected 1000", w, gnt);
      end
      for (int b = WIDTH-1; b >= 0; b--) begin
        tests++;
        if (ser_bit !== w[b]) begin
          fails++; $display("FAIL edge_ser_bit[%0d][%0d]: got %b expected %b", w, b, ser_bit, w[b]);
        end
        tick();
      end
      tests++;
      if (done !== 1'b1 || done_id !== 2'd3 || residue !== RW'(exp_r) || divisible !== (exp_r == 0)) begin
        fails++; $display("FAIL edge_result[%0d]: got done=%b id=%0d res=%0d div=%b, expected 1 3 %0d %b",
                          w, done, done_id, residue, divisible, exp_r, exp_r == 0);
      end
      req = '0;
      tick();
      tests++;
      if (ser_bit !== 1'b0 || busy !== 1'b0) begin
        fails++; $display("FAIL edge_idle[%0d]: got ser=%b busy=%b expected 0 0", w, ser_bit, busy);
      end
    end
  endtask

  task automatic test_random();
    int ptr, pick, n, exp_r;
    logic [NREQ-1:0]  mask;
    logic [WIDTH-1:0] latched;
    apply_reset();
    ptr = 0;
    for (int it = 0; it < 40; it++) begin
      mask     = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      req_data = $urandom();
      req      = mask;
      pick = -1;
      for (int k = 0; k < NREQ; k++)
        if (pick < 0 && mask[(ptr + k) % NREQ]) pick = (ptr + k) % NREQ;
      latched = req_data[pick*WIDTH +: WIDTH];
      exp_r   = int'(latched) % DIVISOR;
      tick();
      tests++;
      if (gnt !== 4'(1 << pick) || busy !== 1'b1) begin
        fails++; $display("FAIL rand_grant[%0d]: got gnt=%b busy=%b expected %b 1", it, gnt, busy, 4'(1 << pick));
      end
      n = 0;
      while (done !== 1'b1 && n < 20) begin
        req_data = $urandom();
        req      = NREQ'($urandom());
        tick();
        n++;
        tests++;
        if (gnt !== 4'(1 << pick)) begin
          fails++; $display("FAIL rand_gnt_hold[%0d]: got %b expected %b", it, gnt, 4'(1 << pick));
        end
      end
      tests++;
      if (n !== WIDTH || done_id !== IW'(pick) || residue !== RW'(exp_r) || divisible !== (exp_r == 0)) begin
        fails++; $display("FAIL rand_result[%0d]: got n=%0d id=%0d res=%0d div=%b, expected %0d %0d %0d %b",
                          it, n, done_id, residue, divisible, WIDTH, pick, exp_r, exp_r == 0);
      end
      ptr = (pick + 1) % NREQ;
      req = '0;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_trace();
    test_round_robin();
    test_reset_midway();
    test_edge_words();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
